// File: rtl/snake_pkg.sv
// Shared grid geometry, direction/state encodings and reset placement for the snake body.
package snake_pkg;

    localparam int GRID_W  = 64;
    localparam int GRID_H  = 48;
    localparam int MAX_LEN = 100;
    localparam int N_APPLE = 5;
    localparam int COORD_W = 6;
    localparam int LEN_W   = 7;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_COMMIT = 2'b10,
        ST_DEAD   = 2'b11
    } state_e;

    localparam logic [COORD_W-1:0] HEAD_X0 = 6'd32;
    localparam logic [COORD_W-1:0] HEAD_Y0 = 6'd24;
    localparam logic [LEN_W-1:0]   LEN0    = 7'd3;

    // Up/down and left/right differ only in bit 0.
    function automatic dir_e opposite(input dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head position and wall test for one step in the given direction.
module snake_next_head
    import snake_pkg::*;
(
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  dir_e               dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               wall_hit
);

    always_comb begin
        next_x = head_x;
        next_y = head_y;
        case (dir)
            DIR_UP:    next_y = head_y - 6'd1;
            DIR_DOWN:  next_y = head_y + 6'd1;
            DIR_LEFT:  next_x = head_x - 6'd1;
            DIR_RIGHT: next_x = head_x + 6'd1;
        endcase
        // Border row/column is wall; a live head never sits on it, so no wrap case arises.
        wall_hit = (next_x == '0) || (next_x >= COORD_W'(GRID_W - 1)) ||
                   (next_y == '0) || (next_y >= COORD_W'(GRID_H - 1));
    end

endmodule

// File: rtl/snake_body.sv
// Snake body store with step FSM IDLE -> CALC -> COMMIT (or DEAD on collision).
// Define SNAKE_SELF_HIT_EN to make body collisions fatal; otherwise only walls kill.
module snake_body #(
    parameter int MAX_LEN = snake_pkg::MAX_LEN,
    parameter int N_APPLE = snake_pkg::N_APPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_tick,
    input  logic [1:0]           dir_in,
    input  logic                 dir_valid,
    input  logic [6*N_APPLE-1:0] apple_x,
    input  logic [6*N_APPLE-1:0] apple_y,
    output logic [6*MAX_LEN-1:0] snake_x,
    output logic [6*MAX_LEN-1:0] snake_y,
    output logic [6:0]           length,
    output logic [N_APPLE-1:0]   eaten,
    output logic                 busy,
    output logic                 dead
);
    import snake_pkg::*;

    localparam int BUS_W = COORD_W * MAX_LEN;

    state_e               state_q, state_d;
    dir_e                 dir_q, dir_d;
    logic [BUS_W-1:0]     snake_x_q, snake_x_d;
    logic [BUS_W-1:0]     snake_y_q, snake_y_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [N_APPLE-1:0]   eaten_q, eaten_d;
    logic                 busy_q, busy_d;
    logic                 dead_q, dead_d;

    // Step result captured at the CALC edge and applied at the COMMIT edge.
    logic [COORD_W-1:0]   nx_q, nx_d;
    logic [COORD_W-1:0]   ny_q, ny_d;
    logic                 kill_q, kill_d;
    logic [N_APPLE-1:0]   hit_q, hit_d;

    logic [COORD_W-1:0]   nh_x, nh_y;
    logic                 wall_hit;
    logic                 self_hit;
    logic [N_APPLE-1:0]   apple_hit;
    logic [LEN_W-1:0]     grown_len;
    logic [BUS_W-1:0]     commit_x, commit_y;

    function automatic logic [BUS_W-1:0] init_bus(input logic [COORD_W-1:0] head,
                                                  input logic               trail_left);
        logic [BUS_W-1:0] bus;
        bus = '0;
        for (int k = 0; k < int'(LEN0); k++) begin
            bus[COORD_W*(MAX_LEN-1-k) +: COORD_W] = head - (trail_left ? COORD_W'(k) : '0);
        end
        return bus;
    endfunction

    snake_next_head u_next_head (
        .head_x   (snake_x_q[COORD_W*(MAX_LEN-1) +: COORD_W]),
        .head_y   (snake_y_q[COORD_W*(MAX_LEN-1) +: COORD_W]),
        .dir      (dir_q),
        .next_x   (nh_x),
        .next_y   (nh_y),
        .wall_hit (wall_hit)
    );

    always_comb begin
        apple_hit = '0;
        for (int i = 0; i < N_APPLE; i++) begin
            apple_hit[i] = (apple_x[COORD_W*i +: COORD_W] == nh_x) &&
                           (apple_y[COORD_W*i +: COORD_W] == nh_y);
        end
    end

`ifdef SNAKE_SELF_HIT_EN
    int tail_idx;

    // The current tail moves away this step unless the snake grows, so it may be entered.
    always_comb begin
        tail_idx = MAX_LEN - int'(len_q);
        self_hit = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if ((snake_x_q[COORD_W*k +: COORD_W] == nh_x) &&
                (snake_y_q[COORD_W*k +: COORD_W] == nh_y) &&
                !((k == tail_idx) && (apple_hit == '0))) begin
                self_hit = 1'b1;
            end
        end
    end
`else
    assign self_hit = 1'b0;
`endif

    // Shift toward slot 0, then clear everything below the new tail so idle slots read (0,0).
    always_comb begin
        grown_len = len_q;
        if ((hit_q != '0) && (len_q < LEN_W'(MAX_LEN))) begin
            grown_len = len_q + 7'd1;
        end
        commit_x = {nx_q, snake_x_q[BUS_W-1:COORD_W]};
        commit_y = {ny_q, snake_y_q[BUS_W-1:COORD_W]};
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k < MAX_LEN - int'(grown_len)) begin
                commit_x[COORD_W*k +: COORD_W] = '0;
                commit_y[COORD_W*k +: COORD_W] = '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        snake_x_d = snake_x_q;
        snake_y_d = snake_y_q;
        len_d     = len_q;
        eaten_d   = '0;
        busy_d    = busy_q;
        dead_d    = dead_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        kill_d    = kill_q;
        hit_d     = hit_q;

        if (dir_valid && (dir_e'(dir_in) != opposite(dir_q))) begin
            dir_d = dir_e'(dir_in);
        end

        case (state_q)
            ST_IDLE: begin
                if (move_tick) begin
                    state_d = ST_CALC;
                    busy_d  = 1'b1;
                end
            end
            ST_CALC: begin
                nx_d    = nh_x;
                ny_d    = nh_y;
                kill_d  = wall_hit | self_hit;
                hit_d   = wall_hit ? '0 : apple_hit;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                busy_d = 1'b0;
                if (kill_q) begin
                    state_d = ST_DEAD;
                    dead_d  = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    eaten_d   = hit_q;
                    len_d     = grown_len;
                    snake_x_d = commit_x;
                    snake_y_d = commit_y;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_RIGHT;
            snake_x_q <= init_bus(HEAD_X0, 1'b1);
            snake_y_q <= init_bus(HEAD_Y0, 1'b0);
            len_q     <= LEN0;
            eaten_q   <= '0;
            busy_q    <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            snake_x_q <= snake_x_d;
            snake_y_q <= snake_y_d;
            len_q     <= len_d;
            eaten_q   <= eaten_d;
            busy_q    <= busy_d;
            dead_q    <= dead_d;
        end
        nx_q   <= nx_d;
        ny_q   <= ny_d;
        kill_q <= kill_d;
        hit_q  <= hit_d;
    end

    assign snake_x = snake_x_q;
    assign snake_y = snake_y_q;
    assign length  = len_q;
    assign eaten   = eaten_q;
    assign busy    = busy_q;
    assign dead    = dead_q;

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: queue-based snake model checked every cycle, plus directed literal checks.
module tb_snake_body;

    localparam int ML = 100;
    localparam int NA = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              move_tick = 1'b0;
    logic [1:0]        dir_in = 2'b00;
    logic              dir_valid = 1'b0;
    logic [6*NA-1:0]   apple_x = '0;
    logic [6*NA-1:0]   apple_y = '0;
    logic [6*ML-1:0]   snake_x;
    logic [6*ML-1:0]   snake_y;
    logic [6:0]        length;
    logic [NA-1:0]     eaten;
    logic              busy;
    logic              dead;

    int n_pass = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    // Model: body as head-first coordinate queues.
    int         mx[$];
    int         my[$];
    logic [1:0] mdir;
    int         pend;
    logic       mdead;
    logic [NA-1:0] meaten;
    int         rx, ry;
    logic       rkill;
    logic [NA-1:0] rhit;
    logic [6*ML-1:0] ex_x, ex_y;

    snake_body #(.MAX_LEN(ML), .N_APPLE(NA)) dut (
        .clk       (clk),
        .rst       (rst),
        .move_tick (move_tick),
        .dir_in    (dir_in),
        .dir_valid (dir_valid),
        .apple_x   (apple_x),
        .apple_y   (apple_y),
        .snake_x   (snake_x),
        .snake_y   (snake_y),
        .length    (length),
        .eaten     (eaten),
        .busy      (busy),
        .dead      (dead)
    );

    always #5 clk = ~clk;

    task automatic check_i(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    task automatic check_b(input string name, input logic [6*ML-1:0] got, input logic [6*ML-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    function automatic int sx(input int k);
        return int'(snake_x[6*k +: 6]);
    endfunction

    function automatic int sy(input int k);
        return int'(snake_y[6*k +: 6]);
    endfunction

    task automatic model_reset();
        mx = {32, 31, 30};
        my = {24, 24, 24};
        mdir = 2'b11;
        pend = 0;
        mdead = 1'b0;
        meaten = '0;
    endtask

    task automatic model_step();
        int dx, dy, n;
        logic wall, self_hit;
        dx = 0;
        dy = 0;
        case (mdir)
            2'b00: dy = -1;
            2'b01: dy = 1;
            2'b10: dx = -1;
            default: dx = 1;
        endcase
        rx = mx[0] + dx;
        ry = my[0] + dy;
        wall = (rx <= 0) || (rx >= 63) || (ry <= 0) || (ry >= 47);
        rhit = '0;
        for (int i = 0; i < NA; i++)
            if (rx == int'(apple_x[6*i +: 6]) && ry == int'(apple_y[6*i +: 6])) rhit[i] = 1'b1;
        self_hit = 1'b0;
        n = mx.size();
`ifdef SNAKE_SELF_HIT_EN
        for (int i = 0; i < n; i++) begin
            if (!(i == n - 1 && rhit == '0) && mx[i] == rx && my[i] == ry) self_hit = 1'b1;
        end
`endif
        rkill = wall || self_hit;
        if (wall) rhit = '0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            meaten = '0;
            if (pend == 1) begin
                if (rkill) begin
                    mdead = 1'b1;
                end else begin
                    mx.push_front(rx);
                    my.push_front(ry);
                    if (rhit == '0 || mx.size() > ML) begin
                        void'(mx.pop_back());
                        void'(my.pop_back());
                    end
                    meaten = rhit;
                end
            end
            if (pend == 2) model_step();
            if (dir_valid && dir_in != (mdir ^ 2'b01)) mdir = dir_in;
            if (pend > 0) pend--;
            else if (move_tick && !mdead) pend = 2;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            ex_x = '0;
            ex_y = '0;
            for (int i = 0; i < mx.size(); i++) begin
                ex_x[6*(ML-1-i) +: 6] = 6'(mx[i]);
                ex_y[6*(ML-1-i) +: 6] = 6'(my[i]);
            end
            check_b("model_snake_x", snake_x, ex_x);
            check_b("model_snake_y", snake_y, ex_y);
            check_i("model_length", int'(length), mx.size());
            check_i("model_eaten", int'(eaten), int'(meaten));
            check_i("model_busy", int'(busy), (pend != 0) ? 1 : 0);
            check_i("model_dead", int'(dead), int'(mdead));
        end
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk) move_tick = 1'b1;
        @(negedge clk) move_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge clk);
        dir_in = d;
        dir_valid = 1'b1;
        @(negedge clk) dir_valid = 1'b0;
    endtask

    task automatic set_apple(input int i, input int x, input int y);
        apple_x[6*i +: 6] = 6'(x);
        apple_y[6*i +: 6] = 6'(y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check_i("rst_len", int'(length), 3);
        check_i("rst_head_x", sx(99), 32);
        check_i("rst_head_y", sy(99), 24);
        check_i("rst_s98_x", sx(98), 31);
        check_i("rst_s97_x", sx(97), 30);
        check_i("rst_s96_x", sx(96), 0);
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_dead", int'(dead), 0);

        // Plain step right
        tick();
        check_i("step_head_x", sx(99), 33);
        check_i("step_head_y", sy(99), 24);
        check_i("step_tail_x", sx(97), 31);
        check_i("step_s96_x", sx(96), 0);
        check_i("step_s96_y", sy(96), 0);
        check_i("step_len", int'(length), 3);

        // Growth keeps the old tail
        do_reset();
        set_apple(0, 33, 24);
        tick();
        check_i("grow_eaten", int'(eaten), 1);
        check_i("grow_len", int'(length), 4);
        check_i("grow_tail_x", sx(96), 30);
        check_i("grow_tail_y", sy(96), 24);
        @(negedge clk);
        check_i("grow_eaten_clr", int'(eaten), 0);
        apple_x = '0;
        apple_y = '0;

        // Reversal dropped, perpendicular turn taken
        do_reset();
        set_dir(2'b10);
        tick();
        check_i("rev_head_x", sx(99), 33);
        set_dir(2'b00);
        tick();
        check_i("turn_head_x", sx(99), 33);
        check_i("turn_head_y", sy(99), 23);
        do_reset();
        set_dir(2'b00);
        tick();
        check_i("up_head_x", sx(99), 32);
        check_i("up_head_y", sy(99), 23);

        // Held tick yields a single step
        do_reset();
        @(negedge clk) move_tick = 1'b1;
        repeat (3) @(negedge clk);
        move_tick = 1'b0;
        check_i("hold_head_x", sx(99), 33);
        repeat (2) @(negedge clk);
        check_i("hold_head_x2", sx(99), 33);
        check_i("hold_busy", int'(busy), 0);

        // Right wall, with an apple on the wall cell
        do_reset();
        set_apple(2, 63, 24);
        for (int i = 0; i < 30; i++) tick();
        check_i("wall_pre_x", sx(99), 62);
        check_i("wall_pre_dead", int'(dead), 0);
        tick();
        check_i("wall_dead", int'(dead), 1);
        check_i("wall_head_x", sx(99), 62);
        check_i("wall_len", int'(length), 3);
        check_i("wall_eaten", int'(eaten), 0);
        tick();
        check_i("dead_busy", int'(busy), 0);
        check_i("dead_head_x", sx(99), 62);
        check_i("dead_sticky", int'(dead), 1);
        apple_x = '0;
        apple_y = '0;
        do_reset();
        check_i("dead_rst", int'(dead), 0);

        // Length 5 looped back into its own body
        set_apple(0, 33, 24);
        set_apple(1, 34, 24);
        tick();
        check_i("loop_eat0", int'(eaten), 1);
        tick();
        check_i("loop_eat1", int'(eaten), 2);
        check_i("loop_len", int'(length), 5);
        apple_x = '0;
        apple_y = '0;
        set_dir(2'b01);
        tick();
        set_dir(2'b10);
        tick();
        set_dir(2'b00);
        tick();
`ifdef SNAKE_SELF_HIT_EN
        check_i("self_dead", int'(dead), 1);
        check_i("self_head_y", sy(99), 25);
`else
        check_i("self_dead", int'(dead), 0);
        check_i("self_head_y", sy(99), 24);
`endif
        check_i("self_head_x", sx(99), 33);
        check_i("self_len", int'(length), 5);

        // Reset during CALC aborts the step
        do_reset();
        set_apple(0, 33, 24);
        @(negedge clk) move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_i("abort_busy", int'(busy), 0);
        check_i("abort_eaten", int'(eaten), 0);
        check_i("abort_len", int'(length), 3);
        repeat (2) @(negedge clk);
        check_i("abort_head_x", sx(99), 32);
        check_i("abort_eaten2", int'(eaten), 0);
        apple_x = '0;
        apple_y = '0;

        // Reset wins over a same-cycle tick
        @(negedge clk);
        rst = 1'b1;
        move_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        move_tick = 1'b0;
        check_i("rst_tick_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check_i("rst_tick_head_x", sx(99), 32);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 100, meaning the number of segment slots in the packed body buses.
REQ-002 SHALL provide parameter N_APPLE, default 5, meaning the number of apple slots compared per move.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port move_tick, input, 1 bit: one-cycle pulse requesting one snake step.
REQ-006 SHALL have port dir_in, input, 2 bits: requested direction, 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
REQ-007 SHALL have port dir_valid, input, 1 bit: qualifies dir_in.
REQ-008 SHALL have ports apple_x and apple_y, input, 30 bits each: apple i at bits [6i+5:6i].
REQ-009 SHALL have ports snake_x and snake_y, output, 600 bits each: segment k at bits [6k+5:6k], head at k=99, tail at k=100-length.
REQ-010 SHALL have port length, output, 7 bits: the active segment count, 3..100.
REQ-011 SHALL have port eaten, output, 5 bits: one-cycle pulse per apple eaten.
REQ-012 SHALL have port busy, output, 1 bit: high while a step is in progress.
REQ-013 SHALL have port dead, output, 1 bit: sticky game-over flag.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> COMMIT -> IDLE; IDLE -> CALC on move_tick when dead=0; any state -> DEAD on collision at COMMIT; DEAD exits only on rst.
REQ-015 SHALL ignore move_tick while busy or dead; no queuing.
REQ-016 SHALL latch dir_in when dir_valid=1, except a request exactly opposite the current direction, which SHALL be dropped.
REQ-017 SHALL compute the next head in CALC: 6-bit coordinate +/-1 from the head in the current direction, without wrap.
REQ-018 SHALL flag a wall hit when next x==0, x>=63, y==0 or y>=47.
REQ-019 SHALL flag growth when the next head equals any apple slot i (x and y both match), pulsing eaten[i] in COMMIT; multiple matching slots SHALL pulse together.
REQ-020 SHALL flag a self hit when the next head equals any active segment, excluding the current tail when not growing.
REQ-021 SHALL, in COMMIT without collision, shift segments toward lower k by one, place the next head at k=99, and increment length on growth (saturating at 100, eaten still pulses).
REQ-022 SHALL hold every inactive slot (k < 100-length) at x=0,y=0 so downstream lookups resolve it as wall, never as body; the vacated tail slot SHALL be zeroed in the same COMMIT.
REQ-023 SHALL, on collision, set dead=1 and leave snake_x, snake_y and length unchanged; eaten SHALL stay 0.
REQ-024 SHALL update outputs exactly 2 cycles after an accepted move_tick (CALC, then COMMIT edge); busy SHALL be high in CALC and COMMIT.
REQ-025 SHALL let wall hit take priority over growth when both would occur.

Reset
REQ-026 SHALL, on rst, set state IDLE, direction right, length=3, head (32,24), segments 98/97 at (31,24)/(30,24), all other slots 0, eaten=0, busy=0, dead=0.
REQ-027 SHALL give rst priority over move_tick in the same cycle and abort any step in progress with no partial commit.

Configuration
REQ-028 SHALL honour macro SNAKE_SELF_HIT_EN: when defined, self hit kills per REQ-020/023; when undefined, self-hit logic is absent and only walls kill.

Structure
REQ-029 SHALL take GRID_W=64, GRID_H=48, MAX_LEN, N_APPLE, direction encodings, FSM state enum and reset-position constants from shared package snake_pkg.
REQ-030 SHALL place next-head arithmetic and wall test in one combinational sub-module snake_next_head.

Verification
REQ-031 SHALL cover: reset, then tick -> after 2 cycles, head (33,24), tail (31,24), slot 97-3 zero, length 3.
REQ-032 SHALL cover: apple0 at (33,24), tick -> eaten=00001 for one cycle, length 4, tail still (30,24).
REQ-033 SHALL cover: direction right, dir_in=10 (left) -> dropped; dir_in=00 then tick -> head (32,23).
REQ-034 SHALL cover: drive head to x=62 moving right, tick -> dead=1, buses frozen, later ticks ignored until rst.
REQ-035 SHALL cover: length 5 looped into own body with SNAKE_SELF_HIT_EN defined -> dead=1; without it -> step commits.
REQ-036 SHALL cover: rst asserted in CALC cycle -> next cycle equals reset state, eaten=0.
